// File: rtl/conv_input_loader.sv
// ============================================================================
// Module      : conv_input_loader
// Description : Packs a raster 8-bit pixel stream into 32-bit words, writes
//               them to the conv engine input memory, then starts the engine
//               and reports its completion. Optional WAIT-state timeout is
//               enabled with the CONV_LOADER_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_input_loader #(
  parameter int DSIZE   = 256,
  parameter int AW      = $clog2(DSIZE) - 2,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    data_width,
  input  logic [7:0]    data_hight,
  input  logic          load_req,
  input  logic [7:0]    s_pix,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [AW-1:0] mi_addr,
  output logic [31:0]   mi_data,
  output logic          mi_wr,
  output logic          conv_start,
  input  logic          conv_done,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [16:0] DSIZE_LIM = 17'(DSIZE);

  state_t        state_q;
  logic [15:0]   total_q;
  logic [15:0]   pc_q;
  logic [AW-1:0] wa_q;
  logic [31:0]   pack_q;
  logic [31:0]   pack_d;
  logic          s_ready_q;
  logic [AW-1:0] mi_addr_q;
  logic [31:0]   mi_data_q;
  logic          mi_wr_q;
  logic          conv_start_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

`ifdef CONV_LOADER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tcnt_q;
`endif

  logic [15:0] w_total;
  logic        w_xfer;
  logic        w_last;

  assign w_total = 16'(data_width) * 16'(data_hight);
  assign w_xfer  = s_valid & s_ready_q;
  assign w_last  = (pc_q == (total_q - 16'd1));

  // Pack register is cleared after each word, so lanes can simply be OR-ed in.
  always_comb begin
    pack_d = pack_q | ({24'd0, s_pix} << {pc_q[1:0], 3'b000});
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      total_q      <= '0;
      pc_q         <= '0;
      wa_q         <= '0;
      pack_q       <= '0;
      s_ready_q    <= 1'b0;
      mi_addr_q    <= '0;
      mi_data_q    <= '0;
      mi_wr_q      <= 1'b0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef CONV_LOADER_TIMEOUT_EN
      tcnt_q       <= '0;
`endif
    end else begin
      mi_wr_q      <= 1'b0;
      conv_start_q <= 1'b0;
      done_q       <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            total_q <= w_total;
            if ((w_total == 16'd0) || ({1'b0, w_total} > DSIZE_LIM)) begin
              err_q <= 1'b1;
            end else begin
              err_q     <= 1'b0;
              pc_q      <= '0;
              wa_q      <= '0;
              pack_q    <= '0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (w_xfer) begin
            pc_q <= pc_q + 16'd1;
            if ((pc_q[1:0] == 2'd3) || w_last) begin
              mi_wr_q   <= 1'b1;
              mi_addr_q <= wa_q;
              mi_data_q <= pack_d;
              wa_q      <= wa_q + 1'b1;
              pack_q    <= '0;
            end else begin
              pack_q <= pack_d;
            end
            if (w_last) begin
              s_ready_q <= 1'b0;
              state_q   <= ST_START;
            end
          end
        end

        ST_START: begin
          conv_start_q <= 1'b1;
          state_q      <= ST_WAIT;
`ifdef CONV_LOADER_TIMEOUT_EN
          tcnt_q       <= '0;
`endif
        end

        ST_WAIT: begin
          if (conv_done) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
`ifdef CONV_LOADER_TIMEOUT_EN
          else if (tcnt_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
`endif
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign mi_addr    = mi_addr_q;
  assign mi_data    = mi_data_q;
  assign mi_wr      = mi_wr_q;
  assign conv_start = conv_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_input_loader.sv
// ============================================================================
// Module      : tb_conv_input_loader
// Description : Self-checking bench for conv_input_loader (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_input_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    data_width;
  logic [7:0]    data_hight;
  logic          load_req;
  logic [7:0]    s_pix;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] mi_addr;
  logic [31:0]   mi_data;
  logic          mi_wr;
  logic          conv_start;
  logic          conv_done;
  logic          busy;
  logic          done;
  logic          err;

  conv_input_loader #(.DSIZE(256), .AW(AW), .TIMEOUT(65535)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_width (data_width),
    .data_hight (data_hight),
    .load_req   (load_req),
    .s_pix      (s_pix),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .mi_addr    (mi_addr),
    .mi_data    (mi_data),
    .mi_wr      (mi_wr),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t cap[$];
  int  cyc = 0;
  int  starts = 0;
  int  total_chk = 0;
  int  bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/start monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mi_wr === 1'b1) cap.push_back('{int'(mi_addr), mi_data, cyc});
    if (conv_start === 1'b1) starts++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic check_idle_outputs(input string tag);
    total_chk++;
    if (s_ready !== 1'b0 || mi_addr !== '0 || mi_data !== 32'd0 || mi_wr !== 1'b0 ||
        conv_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s: rdy=%b addr=%h data=%h wr=%b start=%b busy=%b done=%b err=%b, required all 0",
               tag, s_ready, mi_addr, mi_data, mi_wr, conv_start, busy, done, err);
    end
  endtask

  // Full load through a reference model: words are little-endian groups of 4 pixels.
  task automatic do_load(input int w, input int h, input int vmode, input bit seq,
                         input int ddelay, input string tag);
    int          total;
    int          words;
    int          i;
    int          n;
    int          tstart;
    bit          v;
    bit          tog;
    bit          acc;
    logic [7:0]  pix [256];
    logic [31:0] exp_w;
    total = w * h;
    words = (total + 3) / 4;
    for (int k = 0; k < total; k++) pix[k] = seq ? 8'(k) : 8'($urandom);
    cap.delete();
    starts = 0;
    @(negedge clk);
    data_width = 8'(w);
    data_hight = 8'(h);
    load_req   = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    total_chk++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s enter_load: busy=%b s_ready=%b err=%b, required 1 1 0", tag, busy, s_ready, err);
    end
    i = 0; n = 0; tog = 1'b1;
    while (i < total && n < 4000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog     = ~tog;
      s_valid = v;
      s_pix   = pix[i];
      acc     = v && (s_ready === 1'b1);
      @(negedge clk);
      if (acc) i++;
      n++;
    end
    total_chk++;
    if (i != total) begin
      bad++;
      $display("FAIL %s stream: accepted=%0d, required %0d", tag, i, total);
    end
    s_valid = 1'b1;
    s_pix   = 8'hEE;
    total_chk++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_drop: s_ready=%b, required 0", tag, s_ready);
    end
    n = 0;
    while (conv_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      s_valid = 1'b0;
      n++;
    end
    s_valid = 1'b0;
    total_chk++;
    if (conv_start !== 1'b1) begin
      bad++;
      $display("FAIL %s start_seen: conv_start=%b after %0d cycles, required 1", tag, conv_start, n);
    end else begin
      tstart = cyc;
      total_chk++;
      if (cap.size() == 0 || cap[$].cyc != tstart - 1) begin
        bad++;
        $display("FAIL %s start_timing: writes=%0d start_cyc=%0d, required start 1 cycle after last write",
                 tag, cap.size(), tstart);
      end
    end
    repeat (ddelay) @(negedge clk);
    total_chk++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s wait_state: done=%b busy=%b, required 0 1", tag, done, busy);
    end
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    total_chk++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s done_pulse: done=%b, required 1", tag, done);
    end
    @(negedge clk);
    total_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || conv_start !== 1'b0) begin
      bad++;
      $display("FAIL %s back_idle: done=%b busy=%b start=%b, required 0 0 0", tag, done, busy, conv_start);
    end
    total_chk++;
    if (starts != 1) begin
      bad++;
      $display("FAIL %s start_count: %0d pulses, required 1", tag, starts);
    end
    total_chk++;
    if (cap.size() != words) begin
      bad++;
      $display("FAIL %s wr_count: %0d writes, required %0d", tag, cap.size(), words);
    end
    for (int k = 0; k < words && k < cap.size(); k++) begin
      exp_w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < total) exp_w = exp_w | (32'(pix[4 * k + j]) << (8 * j));
      total_chk++;
      if (cap[k].addr != k || cap[k].data !== exp_w) begin
        bad++;
        $display("FAIL %s word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 tag, k, cap[k].addr, cap[k].data, k, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    check_idle_outputs("reset_state");
  endtask

  task automatic test_8x8_stream();
    do_load(8, 8, 0, 1'b1, 10, "8x8");
    total_chk++;
    if (cap.size() < 16 || cap[0].data !== 32'h03020100 || cap[15].data !== 32'h3F3E3D3C) begin
      bad++;
      $display("FAIL 8x8 vectors: writes=%0d, required addr0=03020100 addr15=3F3E3D3C", cap.size());
    end
  endtask

  task automatic test_partial_word();
    do_load(5, 5, 0, 1'b1, 0, "5x5");
    total_chk++;
    if (cap.size() != 7 || cap[6].addr != 6 || cap[6].data !== 32'h00000018) begin
      bad++;
      $display("FAIL 5x5 last_word: writes=%0d, required 7 writes with addr6=00000018", cap.size());
    end
  endtask

  task automatic test_oversize(input int w, input int h);
    cap.delete();
    starts = 0;
    @(negedge clk);
    data_width = 8'(w);
    data_hight = 8'(h);
    load_req   = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    total_chk++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL oversize_%0dx%0d flags: err=%b busy=%b s_ready=%b, required 1 0 0", w, h, err, busy, s_ready);
    end
    repeat (6) @(negedge clk);
    total_chk++;
    if (cap.size() != 0 || starts != 0 || busy !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL oversize_%0dx%0d quiet: writes=%0d starts=%0d busy=%b err=%b, required 0 0 0 1",
               w, h, cap.size(), starts, busy, err);
    end
  endtask

  task automatic test_err_clear();
    test_oversize(20, 20);
    do_load(8, 8, 0, 1'b1, 3, "err_clear");
    total_chk++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear sticky: err=%b, required 0", err);
    end
  endtask

  task automatic test_gappy();
    do_load(8, 8, 1, 1'b1, 2, "gappy");
    total_chk++;
    if (cap.size() < 2 || (cap[1].cyc - cap[0].cyc) != 8) begin
      bad++;
      $display("FAIL gappy spacing: writes=%0d, required 8-cycle spacing", cap.size());
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    data_width = 8'd8;
    data_hight = 8'd8;
    load_req   = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    for (int k = 0; k < 30; k++) begin
      s_valid = 1'b1;
      s_pix   = 8'(k);
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    cap.delete();
    starts = 0;
    repeat (5) @(negedge clk);
    total_chk++;
    if (cap.size() != 0 || starts != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset quiet: writes=%0d starts=%0d busy=%b, required 0 0 0", cap.size(), starts, busy);
    end
    do_load(8, 8, 0, 1'b1, 4, "after_reset");
  endtask

  task automatic test_boundaries();
    do_load(1, 1, 0, 1'b0, 1, "1x1");
    do_load(16, 16, 2, 1'b0, 5, "16x16");
    test_oversize(0, 9);
  endtask

  task automatic test_random();
    int w;
    int h;
    for (int r = 0; r < 6; r++) begin
      w = $urandom_range(1, 20);
      h = $urandom_range(1, 20);
      if (w * h > 256) test_oversize(w, h);
      else do_load(w, h, 2, 1'b0, $urandom_range(0, 12), "random");
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    data_width = 8'd0;
    data_hight = 8'd0;
    load_req   = 1'b0;
    s_pix      = 8'd0;
    s_valid    = 1'b0;
    conv_done  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    test_8x8_stream();
    test_partial_word();
    test_err_clear();
    test_gappy();
    test_mid_reset();
    test_boundaries();
    test_random();
    $display("test done: total=%0d bad=%0d", total_chk, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
- Upstream feeder for the conv engine: accepts a raster-order 8-bit pixel stream over a valid/ready handshake and packs 4 pixels per 32-bit word.
- Writes the packed words into the engine's input data memory through the mi_addr/mi_data/mi_wr port.
- After the last word is written, pulses the engine's start, waits for its done, then reports completion.
- Replaces testbench-side memory preloading in system integration.

Parameters:
- DSIZE, 256, input memory size in bytes; must equal the conv engine's DSIZE.
- AW, $clog2(DSIZE)-2, word address width of the input memory port.
- TIMEOUT, 65535, cycles allowed in WAIT before abort; used only with CONV_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted when 1).
- data_width  in  8  image width in pixels; sampled on load_req.
- data_hight  in  8  image height in pixels; sampled on load_req.
- load_req  in  1  single-cycle request to begin a load.
- s_pix  in  8  pixel data.
- s_valid  in  1  pixel valid.
- s_ready  out  1  loader accepts a pixel; transfer when s_valid & s_ready.
- mi_addr  out  AW  input memory word address.
- mi_data  out  32  packed word, pixel 4k+j in bits [8j+7:8j] (little-endian lanes).
- mi_wr  out  1  write strobe, one cycle per word.
- conv_start  out  1  single-cycle start pulse to the conv engine.
- conv_done  in  1  engine completion.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.
- err  out  1  sticky error flag; cleared by the next accepted load_req.

Behaviour:
- Reset (rst_n=1): state IDLE; all outputs 0; counters and pack register cleared. Reset mid-operation aborts immediately, with no further mi_wr or conv_start.
- All outputs are registered.
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE: s_ready=0. On load_req, latch total = data_width*data_hight (16-bit) and clear err.
  - If total==0 or total>DSIZE: set err, stay in IDLE, no writes.
  - Otherwise clear the pixel count pc and word address wa, then go to LOAD.
- load_req while busy is ignored.
- LOAD: s_ready=1.
  - Each accepted pixel is placed in lane pc[1:0] of the pack register; pc increments.
  - When lane 3 fills, or the accepted pixel is the last one (pc==total-1), the next cycle has mi_wr=1, mi_addr=wa, mi_data=packed word. wa then increments and the pack register clears.
  - Unfilled lanes of a final partial word are 0.
  - Back-to-back acceptance is allowed at one pixel per cycle; no stall on write.
  - s_ready drops in the cycle after the last pixel is accepted; further pixels are not accepted.
  - After the last acceptance go to START.
- START: the cycle after the final mi_wr has conv_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until conv_done=1 is sampled. conv_done asserted in the same cycle conv_start is high is accepted. Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Words written = ceil(total/4). mi_wr is never asserted outside LOAD or its trailing cycle.

Optional Feature:
- CONV_LOADER_TIMEOUT_EN defined: a 16-bit counter runs in WAIT. If TIMEOUT cycles elapse without conv_done: set err, skip the done pulse, return to IDLE.
- Undefined: WAIT holds indefinitely and no counter is synthesized.

Test Plan:
- 8x8, pixels 0..63 streamed with s_valid constantly 1:
  - 16 writes at addr 0..15; addr 0 = 0x03020100, addr 15 = 0x3F3E3D3C.
  - conv_start 1 cycle after the write to addr 15.
  - conv_done after 10 cycles gives done exactly 1 cycle later.
- 5x5, pixels 0..24: 7 writes; addr 6 = 0x00000018 (zero-padded partial word).
- 20x20 (400>256) load_req: err=1, busy stays 0, no mi_wr, no conv_start; a following valid 8x8 load_req clears err.
- 8x8 with s_valid toggled every other cycle: identical memory contents and write order as the first scenario; writes spaced by the gaps.
- rst_n pulsed high after 30 pixels: all outputs 0 the next cycle; a subsequent full 8x8 load succeeds from addr 0.
- CONV_LOADER_TIMEOUT_EN, TIMEOUT=100, conv_done never asserted: err=1 after 100 WAIT cycles, done stays 0, state IDLE.
